// File: rtl/bicubic_window_sched.sv
// -----------------------------------------------------------------------------
// bicubic_window_sched
//
// Sequencer placed in front of the bicubic upsampler. Image columns (4 pixels
// each) arrive from the line buffer and are shifted into a sliding 4x4 window.
// When the window holds four valid columns, it is presented to the upsampler
// as a single request. The four response beats are gathered into a 4x4 output
// block, and that block is then offered downstream. At the end of each line
// the window is flushed, so no columns carry over into the next line.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   col_valid/ready   column handshake from the line buffer
//   col_data          column pixels, [CW*r +: CW] = row r
//   col_last          column is the last one of its line
//   bf_req_valid      window request to the upsampler (accepted by bcci_req_ready)
//   win_data          4x4 window, [CW*(4r+c) +: CW] = row r, column c (c=0 oldest)
//   bcci_rsp_valid    upsampler response beat valid (accepted by bf_rsp_ready)
//   bcci_rsp_data     response beat {data4,data3,data2,data1}
//   out_valid/ready   output block handshake
//   out_data          block, [CW*(4j+k) +: CW] = beat j, data(k+1)
//   out_last          block comes from the last window of the line
//   short_line        one-cycle pulse: line ended before a window could form
//   blk_cnt           emitted blocks, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module bicubic_window_sched #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       col_valid,
  output logic                       col_ready,
  input  logic [4*CHANNEL_WIDTH-1:0] col_data,
  input  logic                       col_last,
  output logic                       bf_req_valid,
  input  logic                       bcci_req_ready,
  output logic [16*CHANNEL_WIDTH-1:0] win_data,
  input  logic                       bcci_rsp_valid,
  output logic                       bf_rsp_ready,
  input  logic [4*CHANNEL_WIDTH-1:0] bcci_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [16*CHANNEL_WIDTH-1:0] out_data,
  output logic                       out_last,
  output logic                       short_line,
  output logic [CNT_WIDTH-1:0]       blk_cnt
);

  localparam int CW = CHANNEL_WIDTH;

  // One-hot state bit positions
  localparam int S_ACCEPT  = 0;
  localparam int S_ISSUE   = 1;
  localparam int S_COLLECT = 2;
  localparam int S_SEND    = 3;

  localparam logic [3:0] ST_ACCEPT  = 4'b0001;
  localparam logic [3:0] ST_ISSUE   = 4'b0010;
  localparam logic [3:0] ST_COLLECT = 4'b0100;
  localparam logic [3:0] ST_SEND    = 4'b1000;

  logic [3:0]           state_q, state_d;
  logic [2:0]           fill_cnt_q, fill_cnt_d;
  logic [1:0]           beat_cnt_q, beat_cnt_d;
  logic [16*CW-1:0]     win_q, win_d;
  logic [16*CW-1:0]     out_q, out_d;
  logic                 last_q, last_d;
  logic                 short_q, short_d;
  logic [CNT_WIDTH-1:0] blk_cnt_q, blk_cnt_d;

  logic       col_hs, req_hs, rsp_hs, out_hs;
  logic [2:0] fill_inc;

  assign col_hs   = col_valid & col_ready;
  assign req_hs   = bf_req_valid & bcci_req_ready;
  assign rsp_hs   = bcci_rsp_valid & bf_rsp_ready;
  assign out_hs   = out_valid & out_ready;
  assign fill_inc = fill_cnt_q + 3'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[S_ACCEPT]:  if (col_hs && fill_inc == 3'd4)        state_d = ST_ISSUE;
      state_q[S_ISSUE]:   if (bcci_req_ready)                    state_d = ST_COLLECT;
      state_q[S_COLLECT]: if (rsp_hs && beat_cnt_q == 2'd3)      state_d = ST_SEND;
      state_q[S_SEND]:    if (out_ready)                         state_d = ST_ACCEPT;
      default:                                                   state_d = ST_ACCEPT;
    endcase
  end

  // Output decode
  always_comb begin
    col_ready    = state_q[S_ACCEPT];
    bf_req_valid = state_q[S_ISSUE];
    bf_rsp_ready = state_q[S_COLLECT];
    out_valid    = state_q[S_SEND];
    // last_q can remain set in ACCEPT after a short line; expose it only with a block
    out_last     = state_q[S_SEND] & last_q;
  end

  assign win_data   = win_q;
  assign out_data   = out_q;
  assign short_line = short_q;
  assign blk_cnt    = blk_cnt_q;

  // Datapath and counters
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    beat_cnt_d = beat_cnt_q;
    win_d      = win_q;
    out_d      = out_q;
    last_d     = last_q;
    short_d    = 1'b0;
    blk_cnt_d  = blk_cnt_q;

    if (col_hs) begin
      // Shift every row one column towards the oldest slot, new column enters at c=3
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_d[CW*(4*r+c) +: CW] = win_q[CW*(4*r+c+1) +: CW];
        end
        win_d[CW*(4*r+3) +: CW] = col_data[CW*r +: CW];
      end
      last_d = col_last;
      if (col_last && fill_inc != 3'd4) begin
        fill_cnt_d = 3'd0;
        short_d    = 1'b1;
      end else begin
        fill_cnt_d = fill_inc;
      end
    end

    if (req_hs) begin
      beat_cnt_d = 2'd0;
    end

    if (rsp_hs) begin
      for (int j = 0; j < 4; j++) begin
        if (beat_cnt_q == 2'(j)) begin
          out_d[4*CW*j +: 4*CW] = bcci_rsp_data;
        end
      end
      beat_cnt_d = beat_cnt_q + 2'd1;
    end

    if (out_hs) begin
      blk_cnt_d = blk_cnt_q + CNT_WIDTH'(1);
      // Keep the three newest columns so the next column completes the next window
      fill_cnt_d = last_q ? 3'd0 : 3'd3;
      last_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= 3'd0;
      beat_cnt_q <= 2'd0;
      win_q      <= '0;
      out_q      <= '0;
      last_q     <= 1'b0;
      short_q    <= 1'b0;
      blk_cnt_q  <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      win_q      <= win_d;
      out_q      <= out_d;
      last_q     <= last_d;
      short_q    <= short_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_bicubic_window_sched.sv
module tb_bicubic_window_sched;

  localparam int CW    = 8;
  localparam int CNT_W = 4;
  localparam int WW    = 16*CW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              col_valid = 1'b0;
  logic              col_ready;
  logic [4*CW-1:0]   col_data = '0;
  logic              col_last = 1'b0;
  logic              bf_req_valid;
  logic              bcci_req_ready = 1'b0;
  logic [WW-1:0]     win_data;
  logic              bcci_rsp_valid = 1'b0;
  logic              bf_rsp_ready;
  logic [4*CW-1:0]   bcci_rsp_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WW-1:0]     out_data;
  logic              out_last;
  logic              short_line;
  logic [CNT_W-1:0]  blk_cnt;

  bicubic_window_sched #(.CHANNEL_WIDTH(CW), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data), .col_last(col_last),
    .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready), .win_data(win_data),
    .bcci_rsp_valid(bcci_rsp_valid), .bf_rsp_ready(bf_rsp_ready), .bcci_rsp_data(bcci_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .short_line(short_line), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { logic [WW-1:0] data; bit last; } item_t;
  item_t           exp_req[$];
  item_t           exp_blk[$];
  logic [4*CW-1:0] line_cols[$];
  logic [4*CW-1:0] beats[$];
  bit              collecting = 0;
  bit              cur_last = 0;
  bit              short_exp = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [WW-1:0]   win_log[$];
  logic [WW-1:0]   blk_log[$];
  bit              last_log[$];
  int              short_seen = 0;

  function automatic logic [WW-1:0] mk_win();
    logic [WW-1:0] w;
    int n;
    logic [4*CW-1:0] col;
    n = line_cols.size();
    for (int c = 0; c < 4; c++) begin
      col = line_cols[n-4+c];
      for (int r = 0; r < 4; r++) w[CW*(4*r+c) +: CW] = col[CW*r +: CW];
    end
    return w;
  endfunction

  always @(negedge clk) begin : monitor
    item_t it;
    logic [WW-1:0] blk;
    bit busy;
    if (!rst_n) begin
      exp_req.delete(); exp_blk.delete(); line_cols.delete(); beats.delete();
      collecting = 0; short_exp = 0; exp_cnt = '0;
    end else begin
      busy = (exp_req.size() != 0) || collecting || (exp_blk.size() != 0);
      chk("col_ready", col_ready, !busy);
      chk("bf_req_valid", bf_req_valid, exp_req.size() != 0);
      if (exp_req.size() != 0) chk("win_data", win_data, exp_req[0].data);
      chk("bf_rsp_ready", bf_rsp_ready, collecting);
      chk("out_valid", out_valid, exp_blk.size() != 0);
      if (exp_blk.size() != 0) begin
        chk("out_data", out_data, exp_blk[0].data);
        chk("out_last", out_last, exp_blk[0].last);
      end
      chk("short_line", short_line, short_exp);
      chk("blk_cnt", blk_cnt, exp_cnt);
      if (short_line) short_seen++;
      short_exp = 0;

      if (col_valid && col_ready) begin
        line_cols.push_back(col_data);
        if (line_cols.size() >= 4) begin
          it.data = mk_win(); it.last = col_last; exp_req.push_back(it);
        end else if (col_last) begin
          short_exp = 1;
        end
        if (col_last) line_cols.delete();
      end
      if (bf_req_valid && bcci_req_ready) begin
        win_log.push_back(win_data);
        if (exp_req.size() != 0) begin
          it = exp_req.pop_front();
          cur_last = it.last;
        end
        collecting = 1;
        beats.delete();
      end
      if (bcci_rsp_valid && bf_rsp_ready) begin
        beats.push_back(bcci_rsp_data);
        if (beats.size() == 4) begin
          for (int j = 0; j < 4; j++) blk[4*CW*j +: 4*CW] = beats[j];
          it.data = blk; it.last = cur_last;
          exp_blk.push_back(it);
          collecting = 0;
          beats.delete();
        end
      end
      if (out_valid && out_ready) begin
        blk_log.push_back(out_data);
        last_log.push_back(out_last);
        if (exp_blk.size() != 0) void'(exp_blk.pop_front());
        exp_cnt++;
      end
    end
  end

  // ---------------- upsampler and sink models ----------------
  int pending = 0;
  int stall_req = 0;
  int stall_out = 0;
  bit req_rand = 0, rsp_gaps = 0, spurious = 0, fixed_beats = 0, out_rand = 0;
  bit req_hs_s = 0, rsp_hs_s = 0;

  always @(negedge clk) begin
    req_hs_s = bf_req_valid && bcci_req_ready;
    rsp_hs_s = bcci_rsp_valid && bf_rsp_ready;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pending = 0;
      bcci_req_ready = 1'b0;
      bcci_rsp_valid = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (req_hs_s) pending += 4;
      if (rsp_hs_s) pending--;
      if (bf_req_valid && stall_req > 0) begin
        stall_req--; bcci_req_ready = 1'b0;
      end else begin
        bcci_req_ready = req_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (pending > 0) begin
        bcci_rsp_valid = rsp_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (fixed_beats) bcci_rsp_data = {4{8'(8'h11 * (5 - pending))}};
        else if (rsp_hs_s || req_hs_s) bcci_rsp_data = $urandom;
      end else begin
        bcci_rsp_valid = spurious && ($urandom_range(0, 7) == 0);
        bcci_rsp_data  = $urandom;
      end
      if (out_valid && stall_out > 0) begin
        stall_out--; out_ready = 1'b0;
      end else begin
        out_ready = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_line(input int n, input bit rnd, input logic [7:0] base, input bit gaps);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        col_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      col_valid = 1'b1;
      col_last  = (i == n-1);
      for (int r = 0; r < 4; r++)
        col_data[CW*r +: CW] = rnd ? 8'($urandom) : 8'(base + 16*i + r);
      for (t = 0; t < 2000; t++) begin
        @(negedge clk);
        if (col_ready) break;
      end
      if (t == 2000) begin
        checks++; errors++;
        $display("FAIL col_accept_timeout: column %0d not accepted within 2000 cycles", i);
      end
      @(posedge clk); #1;
    end
    col_valid = 1'b0;
    col_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (col_ready && exp_req.size() == 0 && !collecting && exp_blk.size() == 0) break;
    end
    if (t == 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: design did not return to idle within 3000 cycles");
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col_ready"},    col_ready, 1'b1);
    chk({tag, "_bf_req_valid"}, bf_req_valid, 1'b0);
    chk({tag, "_bf_rsp_ready"}, bf_rsp_ready, 1'b0);
    chk({tag, "_out_valid"},    out_valid, 1'b0);
    chk({tag, "_out_last"},     out_last, 1'b0);
    chk({tag, "_short_line"},   short_line, 1'b0);
    chk({tag, "_blk_cnt"},      blk_cnt, '0);
    chk({tag, "_win_data"},     win_data, '0);
    chk({tag, "_out_data"},     out_data, '0);
  endtask

  task automatic clear_logs();
    win_log.delete(); blk_log.delete(); last_log.delete(); short_seen = 0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0] lp;
    int t;
    @(posedge clk); #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single 4-column ramp line
    clear_logs();
    send_line(4, 0, 8'h00, 0);
    wait_idle();
    chk("t1_req_count", win_log.size(), 1);
    if (win_log.size() > 0) chk("t1_window", win_log[0], 128'h33231303_32221202_31211101_30201000);
    chk("t1_blk_count", blk_log.size(), 1);
    if (last_log.size() > 0) chk("t1_out_last", last_log[0], 1'b1);
    chk("t1_blk_cnt", blk_cnt, 4'd1);

    // 2: 7-column line slides four windows
    clear_logs();
    send_line(7, 0, 8'h00, 0);
    wait_idle();
    chk("t2_blk_count", blk_log.size(), 4);
    if (win_log.size() > 1) chk("t2_window1", win_log[1], 128'h43332313_42322212_41312111_40302010);
    lp = '0;
    for (int i = 0; i < 4 && i < last_log.size(); i++) lp[i] = last_log[i];
    chk("t2_last_pattern", lp, 4'b1000);
    chk("t2_blk_cnt", blk_cnt, 4'd5);

    // 3: short line then a clean 4-column line
    clear_logs();
    send_line(2, 1, 8'h00, 0);
    wait_idle();
    chk("t3_short_pulses", short_seen, 1);
    chk("t3_no_request", win_log.size(), 0);
    send_line(4, 0, 8'h80, 0);
    wait_idle();
    if (win_log.size() > 0) chk("t3_window", win_log[0], 128'hB3A39383_B2A29282_B1A19181_B0A09080);
    chk("t3_blk_cnt", blk_cnt, 4'd6);

    // 4: backpressure on every interface
    clear_logs();
    stall_req = 5; stall_out = 3; rsp_gaps = 1;
    send_line(5, 1, 8'h00, 1);
    wait_idle();
    chk("t4_blk_count", blk_log.size(), 2);
    chk("t4_blk_cnt", blk_cnt, 4'd8);
    rsp_gaps = 0;

    // 5: response ordering
    clear_logs();
    fixed_beats = 1;
    send_line(4, 0, 8'h00, 0);
    wait_idle();
    if (blk_log.size() > 0) chk("t5_block", blk_log[0], 128'h44444444_33333333_22222222_11111111);
    chk("t5_blk_cnt", blk_cnt, 4'd9);
    fixed_beats = 0;

    // Randomised lines, blk_cnt wraps through zero
    req_rand = 1; rsp_gaps = 1; out_rand = 1; spurious = 1;
    for (int l = 0; l < 25; l++) send_line($urandom_range(1, 9), 1, 8'h00, 1);
    wait_idle();
    req_rand = 0; rsp_gaps = 0; out_rand = 0; spurious = 0;

    // 6: reset during collection of beat 2
    send_line(4, 1, 8'h00, 0);
    for (t = 0; t < 500; t++) begin
      @(posedge clk); #2;
      if (collecting && beats.size() == 2) break;
    end
    if (t == 500) begin
      checks++; errors++;
      $display("FAIL t6_reach_beat2: collection did not reach beat 2 within 500 cycles");
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    send_line(4, 0, 8'h00, 0);
    wait_idle();
    chk("t6_blk_count", blk_log.size(), 1);
    if (win_log.size() > 0) chk("t6_window", win_log[0], 128'h33231303_32221202_31211101_30201000);
    chk("t6_blk_cnt", blk_cnt, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
